binary_mul_seq_bi: RTL and testbench

//  Parametrised iterative Booth multiplier; next generation of the 16x16 single-cycle multiplier.

---
 rtl/binary_mul_pkg.sv | 35 +++
 rtl/booth_pp_sel.sv | 30 +++
 rtl/binary_mul_seq_bi.sv | 128 ++++++++++++
 tb/tb_binary_mul_seq_bi.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/binary_mul_pkg.sv
// Shared types and helpers for the iterative Booth multiplier.
// Contents: FSM state enum, Booth digit encodings, iteration count, digit recoding.
package binary_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Booth digits are held as 3-bit two's complement values in the range -2..+2.
    localparam logic [2:0] DIG_Z  = 3'b000;
    localparam logic [2:0] DIG_P1 = 3'b001;
    localparam logic [2:0] DIG_P2 = 3'b010;
    localparam logic [2:0] DIG_M2 = 3'b110;
    localparam logic [2:0] DIG_M1 = 3'b111;

    function automatic int iter_count(input int width, input int radix4);
        return (width + 2) / (1 + radix4);
    endfunction

    // Radix-4 recoding of {b[i+1], b[i], b[i-1]}. Radix-2 reuses it by passing {b[i], b[i], b[i-1]}.
    function automatic logic [2:0] booth_digit(input logic [2:0] trip);
        logic [2:0] dig;
        case (trip)
            3'b001, 3'b010: dig = DIG_P1;
            3'b011:         dig = DIG_P2;
            3'b100:         dig = DIG_M2;
            3'b101, 3'b110: dig = DIG_M1;
            default:        dig = DIG_Z;
        endcase
        return dig;
    endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// Booth partial-product selector: scales the extended multiplicand by a digit
// in -2..+2 and shifts it to the digit position, all in 2*IW-bit arithmetic.
module booth_pp_sel
    import binary_mul_pkg::*;
#(
    parameter int IW = 18,
    parameter int SW = 6
) (
    input  logic [2:0]      digit_i,
    input  logic [IW-1:0]   a_ext_i,
    input  logic [SW-1:0]   shift_i,
    output logic [2*IW-1:0] pp_o
);

    logic [2*IW-1:0] a_wide;
    logic [2*IW-1:0] mag;

    always_comb begin
        a_wide = {{IW{a_ext_i[IW-1]}}, a_ext_i};
        case (digit_i)
            DIG_P1:  mag = a_wide;
            DIG_P2:  mag = a_wide << 1;
            DIG_M1:  mag = -a_wide;
            DIG_M2:  mag = -(a_wide << 1);
            default: mag = '0;
        endcase
        pp_o = mag << shift_i;
    end

endmodule

// File: rtl/binary_mul_seq_bi.sv
// Iterative radix-2/radix-4 Booth multiplier with valid/ready on both sides,
// runtime signed/unsigned mode and a full 2*WIDTH product.
module binary_mul_seq_bi
    import binary_mul_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int RADIX4 = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] P,
    output logic               busy
);

    localparam int IW   = WIDTH + 2;
    localparam int ITER = iter_count(WIDTH, RADIX4);
    localparam int STEP = 1 + RADIX4;
    localparam int CW   = $clog2(ITER + 1);
    localparam int SW   = $clog2(2 * IW);
    localparam bit R4   = (RADIX4 != 0);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      a_q, a_d;
    logic [IW-1:0]      b_q, b_d;
    logic               bm1_q, bm1_d;
    logic [2*IW-1:0]    acc_q, acc_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic               out_valid_q, out_valid_d;

    logic [2:0]         trip;
    logic [2:0]         digit;
    logic [SW-1:0]      shift;
    logic [2*IW-1:0]    pp;

    // B is consumed from its LSB end; the digit position comes from the counter.
    assign trip  = R4 ? {b_q[1], b_q[0], bm1_q} : {b_q[0], b_q[0], bm1_q};
    assign digit = booth_digit(trip);
    assign shift = SW'(cnt_q) << (STEP - 1);

    booth_pp_sel #(
        .IW(IW),
        .SW(SW)
    ) u_pp_sel (
        .digit_i(digit),
        .a_ext_i(a_q),
        .shift_i(shift),
        .pp_o   (pp)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            bm1_q       <= 1'b0;
            acc_q       <= '0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
        end else if (en) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            bm1_q       <= bm1_d;
            acc_q       <= acc_d;
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Registers only load while en=1, so en is already folded into both handshakes here.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        bm1_d       = bm1_q;
        acc_d       = acc_q;
        p_d         = p_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_signed ? {{2{A[WIDTH-1]}}, A} : {2'b00, A};
                    b_d     = in_signed ? {{2{B[WIDTH-1]}}, B} : {2'b00, B};
                    bm1_d   = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_q + pp;
                b_d   = b_q >> STEP;
                bm1_d = R4 ? b_q[1] : b_q[0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d     = DONE;
                    p_d         = acc_d[2*WIDTH-1:0];
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = en & (state_q == IDLE);
    assign busy      = (state_q == CALC);
    assign out_valid = out_valid_q;
    assign P         = p_q;

endmodule

// File: tb/tb_binary_mul_seq_bi.sv
// Directed and randomised checks of binary_mul_seq_bi at WIDTH=16, radix-2 and radix-4
// instances side by side; sel chooses which instance the stimulus exercises.
module tb_binary_mul_seq_bi;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_signed = 1'b0;
    logic           out_ready = 1'b0;
    logic           sel = 1'b0;
    logic [W-1:0]   A = '0;
    logic [W-1:0]   B = '0;

    logic           iv0, iv1;
    logic           in_ready0, in_ready1, ov0, ov1, busy0, busy1;
    logic [2*W-1:0] p0, p1;

    logic           in_ready_m, out_valid_m, busy_m;
    logic [2*W-1:0] p_m;
    int             iter_cur;

    int tests = 0;
    int fails = 0;

    assign iv0         = in_valid & ~sel;
    assign iv1         = in_valid & sel;
    assign in_ready_m  = sel ? in_ready1 : in_ready0;
    assign out_valid_m = sel ? ov1 : ov0;
    assign busy_m      = sel ? busy1 : busy0;
    assign p_m         = sel ? p1 : p0;
    assign iter_cur    = sel ? 9 : 18;

    always #5 clk = ~clk;

    binary_mul_seq_bi #(.WIDTH(W), .RADIX4(0)) u_r2 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(iv0), .in_ready(in_ready0),
        .in_signed(in_signed), .A(A), .B(B), .out_valid(ov0), .out_ready(out_ready),
        .P(p0), .busy(busy0)
    );

    binary_mul_seq_bi #(.WIDTH(W), .RADIX4(1)) u_r4 (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(iv1), .in_ready(in_ready1),
        .in_signed(in_signed), .A(A), .B(B), .out_valid(ov1), .out_ready(out_ready),
        .P(p1), .busy(busy1)
    );

    // Directed corner vectors: mode, A, B, expected product.
    logic           cv_s [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [W-1:0]   cv_a [10] = '{16'h8000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                                  16'h0000, 16'h0000, 16'h7FFF, 16'h8000, 16'h8000};
    logic [W-1:0]   cv_b [10] = '{16'h8000, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0001,
                                  16'hBEEF, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF};
    logic [2*W-1:0] cv_p [10] = '{32'h4000_0000, 32'hFFFE_0001, 32'h0000_0001, 32'hFFFF_FFFF,
                                  32'h0000_FFFF, 32'h0000_0000, 32'h0000_0000, 32'hC000_8000,
                                  32'h4000_0000, 32'hC000_8000};

    // Presents one operand pair at the current negedge; returns one negedge after the accept edge.
    task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        in_signed = s;
        A         = a;
        B         = b;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!out_valid_m && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        if (!out_valid_m) cycles = -1;
    endtask

    task automatic finish_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; en = 1'b1;
        @(negedge clk);
        tests++; if (out_valid_m !== 1'b0) begin fails++; $display("FAIL reset_out_valid r%0d: got %b want 0", sel, out_valid_m); end
        tests++; if (busy_m !== 1'b0) begin fails++; $display("FAIL reset_busy r%0d: got %b want 0", sel, busy_m); end
        tests++; if (p_m !== 32'h0) begin fails++; $display("FAIL reset_P r%0d: got %h want 00000000", sel, p_m); end
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (in_ready_m !== 1'b1) begin fails++; $display("FAIL reset_in_ready r%0d: got %b want 1", sel, in_ready_m); end
        $display("[TB] r%0d reset done", sel);
    endtask

    task automatic test_corners();
        int c;
        for (int i = 0; i < 10; i++) begin
            start_op(cv_s[i], cv_a[i], cv_b[i]);
            wait_done(c);
            tests++; if (c !== iter_cur) begin fails++; $display("FAIL corner_latency r%0d #%0d: got %0d want %0d", sel, i, c, iter_cur); end
            tests++; if (p_m !== cv_p[i]) begin fails++; $display("FAIL corner_P r%0d #%0d: got %h want %h", sel, i, p_m, cv_p[i]); end
            finish_out();
            tests++; if (out_valid_m !== 1'b0) begin fails++; $display("FAIL corner_drain r%0d #%0d: got out_valid %b want 0", sel, i, out_valid_m); end
            tests++; if (in_ready_m !== 1'b1) begin fails++; $display("FAIL corner_idle r%0d #%0d: got in_ready %b want 1", sel, i, in_ready_m); end
            $display("[TB] r%0d corner #%0d s=%0d %h*%h -> %h (%0d cycles)", sel, i, cv_s[i], cv_a[i], cv_b[i], p_m, c);
        end
    endtask

    task automatic test_stall();
        int c;
        start_op(1'b0, 16'd3, 16'd5);
        wait_done(c);
        in_signed = 1'b0; A = 16'd9; B = 16'd9; in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (out_valid_m !== 1'b1 || p_m !== 32'd15 || in_ready_m !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold r%0d cyc%0d: got ov=%b P=%h rdy=%b want ov=1 P=0000000f rdy=0", sel, i, out_valid_m, p_m, in_ready_m);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        tests++;
        if (out_valid_m !== 1'b0 || busy_m !== 1'b0 || in_ready_m !== 1'b1) begin
            fails++;
            $display("FAIL stall_release r%0d: got ov=%b busy=%b rdy=%b want ov=0 busy=0 rdy=1", sel, out_valid_m, busy_m, in_ready_m);
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(c);
        tests++; if (c !== iter_cur) begin fails++; $display("FAIL stall_latency r%0d: got %0d want %0d", sel, c, iter_cur); end
        tests++; if (p_m !== 32'd81) begin fails++; $display("FAIL stall_P r%0d: got %h want 00000051", sel, p_m); end
        finish_out();
        $display("[TB] r%0d stall 3*5 held, then 9*9 -> %h", sel, p_m);
    endtask

    task automatic test_enable();
        int c = 0;
        logic [2*W-1:0] exp_p = -32'sd3962745;
        start_op(1'b1, 16'd12345, 16'hFEBF);
        while (!out_valid_m && c < 200) begin
            @(negedge clk);
            c++;
            if (c == 4) en = 1'b0;
            if (c == 5) begin
                tests++;
                if (in_ready_m !== 1'b0 || busy_m !== 1'b1) begin
                    fails++;
                    $display("FAIL enable_freeze r%0d: got rdy=%b busy=%b want rdy=0 busy=1", sel, in_ready_m, busy_m);
                end
            end
            if (c == 7) en = 1'b1;
        end
        tests++; if (c !== iter_cur + 3) begin fails++; $display("FAIL enable_latency r%0d: got %0d want %0d", sel, c, iter_cur + 3); end
        tests++; if (p_m !== exp_p) begin fails++; $display("FAIL enable_P r%0d: got %h want %h", sel, p_m, exp_p); end
        en = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++; if (out_valid_m !== 1'b1) begin fails++; $display("FAIL enable_blocks_out r%0d: got ov=%b want 1", sel, out_valid_m); end
        end
        en = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        tests++; if (out_valid_m !== 1'b0) begin fails++; $display("FAIL enable_drain r%0d: got ov=%b want 0", sel, out_valid_m); end
        $display("[TB] r%0d enable stall 12345*-321 -> %h in %0d cycles", sel, p_m, c);
    endtask

    task automatic test_reset_abort();
        int c;
        start_op(1'b0, 16'd100, 16'd100);
        repeat (3) @(negedge clk);
        tests++; if (busy_m !== 1'b1) begin fails++; $display("FAIL abort_busy_before r%0d: got %b want 1", sel, busy_m); end
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid_m !== 1'b0 || busy_m !== 1'b0 || p_m !== 32'h0) begin
            fails++;
            $display("FAIL abort_state r%0d: got ov=%b busy=%b P=%h want ov=0 busy=0 P=00000000", sel, out_valid_m, busy_m, p_m);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (in_ready_m !== 1'b1) begin fails++; $display("FAIL abort_in_ready r%0d: got %b want 1", sel, in_ready_m); end
        start_op(1'b0, 16'd7, 16'd6);
        wait_done(c);
        tests++; if (p_m !== 32'd42) begin fails++; $display("FAIL abort_next_P r%0d: got %h want 0000002a", sel, p_m); end
        finish_out();
        $display("[TB] r%0d abort, then 7*6 -> %h", sel, p_m);
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] expq[$];
        logic [2*W-1:0] exp_p;
        logic           acc, ohs;
        int             done_n = 0;
        int             cyc = 0;
        in_valid = 1'b0;
        while (done_n < 12 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            en        = ($urandom_range(3) != 0);
            out_ready = 1'($urandom_range(1));
            if (!in_valid && $urandom_range(1) == 1) begin
                A         = W'($urandom);
                B         = W'($urandom);
                in_signed = 1'($urandom_range(1));
                in_valid  = 1'b1;
            end
            #1;
            acc = in_valid && in_ready_m;
            ohs = out_valid_m && out_ready && en;
            if (ohs) begin
                tests++;
                if (expq.size() == 0) begin
                    fails++;
                    $display("FAIL b2b_spurious r%0d: got P=%h with no product pending", sel, p_m);
                end else begin
                    exp_p = expq.pop_front();
                    if (p_m !== exp_p) begin
                        fails++;
                        $display("FAIL b2b_P r%0d #%0d: got %h want %h", sel, done_n, p_m, exp_p);
                    end else begin
                        $display("[TB] r%0d b2b #%0d P=%h", sel, done_n, p_m);
                    end
                end
                done_n++;
            end
            if (acc) begin
                if (in_signed) exp_p = $signed({{W{A[W-1]}}, A}) * $signed({{W{B[W-1]}}, B});
                else           exp_p = {{W{1'b0}}, A} * {{W{1'b0}}, B};
                expq.push_back(exp_p);
            end
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
        end
        tests++; if (done_n !== 12) begin fails++; $display("FAIL b2b_count r%0d: got %0d products want 12", sel, done_n); end
        in_valid = 1'b0; en = 1'b1; out_ready = 1'b1;
        repeat (25) @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < 2; r++) begin
            sel = 1'(r);
            test_reset();
            test_corners();
            test_stall();
            test_enable();
            test_reset_abort();
            test_back_to_back();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
